// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock,
// LSB nibble first, through a single 4-bit adder and a carry register.
// Control is an IDLE/RUN/DONE FSM with valid/ready handshakes on both sides.
// Optional feature: define NIBBLE_SERIAL_OVF_EN to add the signed-overflow
// output ovf (registered, valid with out_valid).
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W+1:0] bit_base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       nib_sum;
    logic             accept;
    logic             last_nib;

    // One nibble of the ripple: 4-bit sum in [3:0], carry-out in [4].
    function automatic logic [4:0] nibble_add(input logic [3:0] x,
                                              input logic [3:0] y,
                                              input logic       ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

`ifdef NIBBLE_SERIAL_OVF_EN
    // Carry into bit 3 of a nibble, i.e. into the operand sign bit when the
    // nibble is the most-significant one.
    function automatic logic carry_into_bit3(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       ci);
        logic [3:0] low;
        low = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
        return low[3];
    endfunction
`endif

    assign accept   = in_valid && in_ready;
    assign last_nib = (state_q == RUN) && (idx_q == LAST_IDX);
    assign bit_base = {idx_q, 2'b00};

    // Select the current nibble of each latched operand and add it.
    always_comb begin
        nib_a   = a_q[bit_base +: 4];
        nib_b   = b_q[bit_base +: 4];
        nib_sum = nibble_add(nib_a, nib_b, carry_q);
    end

    // State register; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance; pure data, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Serial datapath: seed carry on acceptance, then one nibble per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            c_out   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            carry_q <= c_in;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum[bit_base +: 4] <= nib_sum[3:0];
            carry_q            <= nib_sum[4];
            idx_q              <= idx_q + 1'b1;
            if (last_nib) begin
                c_out <= nib_sum[4];
`ifdef NIBBLE_SERIAL_OVF_EN
                ovf   <= carry_into_bit3(nib_a, nib_b, carry_q) ^ nib_sum[4];
`endif
            end
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit digits per operand; legal range 1..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operand set a, b and c_in is presented.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-006 SHALL have port a, input, 4*NIBBLES: operand A.
REQ-007 SHALL have port b, input, 4*NIBBLES: operand B.
REQ-008 SHALL have port c_in, input, 1: carry into the least-significant nibble.
REQ-009 SHALL have port out_valid, output, 1: sum and c_out are valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port sum, output, 4*NIBBLES: registered result.
REQ-012 SHALL have port c_out, output, 1: carry out of the most-significant nibble.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready is 1 only in IDLE, and out_valid is 1 only in DONE.
REQ-014 SHALL accept an operand set on a rising edge where in_valid=1 and in_ready=1: latch a, b and c_in, load the carry register with c_in, clear the nibble index, and enter RUN.
REQ-015 SHALL ignore in_valid, a, b and c_in in RUN and DONE; latched operands are immune to later input changes.
REQ-016 SHALL, on each RUN edge with index i, write sum[4i+3:4i] = A[i] + B[i] + carry, set carry to the 4-bit carry-out, and increment i; evaluation is LSB nibble first.
REQ-017 SHALL leave RUN for DONE on the edge that processes nibble NIBBLES-1; c_out then equals the final carry.
REQ-018 SHALL assert out_valid exactly NIBBLES cycles after the accepting edge; latency is constant and independent of the data.
REQ-019 SHALL hold sum, c_out and out_valid stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-020 SHALL NOT accept a new operand set on the same edge a result is consumed; the next acceptance is no earlier than the following edge (maximum throughput 1 result per NIBBLES+2 cycles).
REQ-021 SHALL wrap the sum modulo 2^(4*NIBBLES), with the overflow bit reported only on c_out.
REQ-022 SHALL keep sum and c_out unchanged in IDLE, holding the last result; partial writes are visible in RUN but not qualified.

Reset
REQ-023 SHALL, on any edge with rst=1, regardless of state (including mid-RUN), set the state to IDLE, sum=0, c_out=0, carry=0 and index=0; in_ready is 1 and out_valid is 0 after the edge.
REQ-024 SHALL discard any in-flight operation on reset and emit no result for it.
REQ-025 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-026 SHALL, with macro NIBBLE_SERIAL_OVF_EN defined, add output port ovf (1 bit): the signed two's-complement overflow, equal to the carry into bit 4*NIBBLES-1 XOR c_out, registered and valid with out_valid, and reset to 0.
REQ-027 SHALL, without NIBBLE_SERIAL_OVF_EN, have no ovf port and no associated logic; all other behaviour is identical.

Verification (NIBBLES=4)
REQ-028 SHALL check: a=0xFFFF, b=0x0001, c_in=0 -> out_valid 4 cycles after acceptance, sum=0x0000, c_out=1, ovf=0.
REQ-029 SHALL check: a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1 (macro defined); without the macro, same sum and c_out and no ovf port.
REQ-030 SHALL check: a=0x1234, b=0x4321, c_in=1 with out_ready=0 for 5 cycles -> sum=0x5556 and c_out=0 held stable with out_valid=1 throughout, then IDLE one edge after out_ready=1.
REQ-031 SHALL check: in_valid held at 1 with changing a/b during RUN -> the result reflects only the first latched set, and in_ready=0 until IDLE.
REQ-032 SHALL check: rst=1 for one edge at RUN index 2 -> sum=0, c_out=0, out_valid=0, in_ready=1 next cycle; no result is emitted; a new set 0x0001+0x0001 then yields 0x0002.
REQ-033 SHALL check: back-to-back in_valid with out_ready=1 always -> a new acceptance every 6 cycles, with each result correct.
